// File: rtl/sort_result_collector_if.sv
// Result-stream bundle between the sort stage, the collector and its reader.
// master: the collector side (consumes beats, presents frames).
interface sort_result_collector_if;
    logic        in_valid;
    logic [5:0]  in_result;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic [7:0]  out_sum;
    logic [5:0]  out_max;
    logic [5:0]  out_min;

    modport master (
        input  in_valid, in_result, out_ready,
        output out_valid, out_data, out_sum, out_max, out_min
    );

    modport slave (
        output in_valid, in_result, out_ready,
        input  out_valid, out_data, out_sum, out_max, out_min
    );
endinterface

// File: rtl/sort_result_collector.sv
// Collects 4-beat signed result frames, computes sum/max/min, buffers in a FIFO.
// Optional saturating truncation counter: define RC_ERR_CNT_EN.
module sort_result_collector #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    sort_result_collector_if.master bus,
    output logic err,
    output logic ovf
`ifdef RC_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t state, state_nx;
    logic [1:0] beat, beat_nx;
    logic push, trunc, pop, accept;

    logic signed [5:0] b0, b1, b2, b3;
    logic signed [7:0] sum;
    logic signed [5:0] mx01, mx23, mx, mn01, mn23, mn;
    logic [43:0] entry, head_e;

    logic [43:0]   mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            beat  <= 2'd0;
        end else begin
            state <= state_nx;
            beat  <= beat_nx;
        end
    end

    always_comb begin
        state_nx = state;
        beat_nx  = beat;
        push     = 1'b0;
        trunc    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nx = COLLECT;
                    beat_nx  = 2'd1;
                end
            end
            COLLECT: begin
                if (!bus.in_valid) begin
                    trunc    = 1'b1;
                    state_nx = IDLE;
                    beat_nx  = 2'd0;
                end else if (beat == 2'd3) begin
                    push     = 1'b1;
                    state_nx = IDLE;
                    beat_nx  = 2'd0;
                end else begin
                    beat_nx = beat + 2'd1;
                end
            end
        endcase
    end

    // beat 3 is never registered: it feeds the push straight from the bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b0 <= '0;
            b1 <= '0;
            b2 <= '0;
        end else if (bus.in_valid) begin
            case (beat)
                2'd0:    b0 <= bus.in_result;
                2'd1:    b1 <= bus.in_result;
                2'd2:    b2 <= bus.in_result;
                default: ;
            endcase
        end
    end

    assign b3   = bus.in_result;
    assign sum  = 8'(b0) + 8'(b1) + 8'(b2) + 8'(b3);
    assign mx01 = (b0 > b1) ? b0 : b1;
    assign mx23 = (b2 > b3) ? b2 : b3;
    assign mx   = (mx01 > mx23) ? mx01 : mx23;
    assign mn01 = (b0 < b1) ? b0 : b1;
    assign mn23 = (b2 < b3) ? b2 : b3;
    assign mn   = (mn01 < mn23) ? mn01 : mn23;
    assign entry = {b0, b1, b2, b3, sum, mx, mn};

    assign pop    = (count != '0) && bus.out_ready;
    assign accept = push && ((count < CW'(DEPTH)) || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            err <= trunc;
            ovf <= push && !accept;
            if (pop)
                head <= head + AW'(1);
            if (accept)
                tail <= tail + AW'(1);
            if (accept && !pop)
                count <= count + CW'(1);
            else if (pop && !accept)
                count <= count - CW'(1);
        end
    end

    // storage needs no reset: the head is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (accept)
            mem[tail] <= entry;
    end

    assign head_e        = (count != '0) ? mem[head] : '0;
    assign bus.out_valid = (count != '0);
    assign bus.out_data  = head_e[43:20];
    assign bus.out_sum   = head_e[19:12];
    assign bus.out_max   = head_e[11:6];
    assign bus.out_min   = head_e[5:0];

`ifdef RC_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= 8'd0;
        else if (err && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_sort_result_collector.sv
// Bench for sort_result_collector: table vectors, corner sequences, and a
// random run against a queue-based frame model.
module tb_sort_result_collector;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    logic err, ovf;
`ifdef RC_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    sort_result_collector_if bus ();

    sort_result_collector #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master),
        .err   (err),
        .ovf   (ovf)
`ifdef RC_ERR_CNT_EN
        ,
        .err_cnt(err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] d;
        logic [7:0]  s;
        logic [5:0]  mx;
        logic [5:0]  mn;
    } fr_t;

    fr_t mq[$];
    int  part[$];
    bit  err_e, ovf_e;
    int  cnt_e;

    typedef struct {
        logic [5:0]  b0, b1, b2, b3;
        logic [23:0] data;
        logic [7:0]  sum;
        logic [5:0]  mx, mn;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic fr_t mk_frame(input int p0, input int p1,
                                     input int p2, input int p3);
        fr_t f;
        int v[4];
        int hi, lo;
        v = '{p0, p1, p2, p3};
        hi = v[0];
        lo = v[0];
        foreach (v[i]) begin
            if (v[i] > hi) hi = v[i];
            if (v[i] < lo) lo = v[i];
        end
        f.d  = {6'(p0), 6'(p1), 6'(p2), 6'(p3)};
        f.s  = 8'(p0 + p1 + p2 + p3);
        f.mx = 6'(hi);
        f.mn = 6'(lo);
        return f;
    endfunction

    task automatic model_reset();
        mq.delete();
        part.delete();
        err_e = 0;
        ovf_e = 0;
        cnt_e = 0;
    endtask

    task automatic model_step(input logic v, input logic [5:0] r,
                              input logic rdy);
        bit   popped;
        bit   done;
        fr_t  f;
        popped = (mq.size() > 0) && rdy;
        done   = 0;
        err_e  = 0;
        ovf_e  = 0;
        if (v) begin
            part.push_back(int'($signed(r)));
            if (part.size() == 4) begin
                done = 1;
                f = mk_frame(part[0], part[1], part[2], part[3]);
                part.delete();
            end
        end else if (part.size() > 0) begin
            err_e = 1;
            part.delete();
            if (cnt_e < 255) cnt_e++;
        end
        if (popped) void'(mq.pop_front());
        if (done) begin
            if (mq.size() < DEPTH) mq.push_back(f);
            else ovf_e = 1;
        end
    endtask

    task automatic model_cmp();
        chk("out_valid", bus.out_valid, 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("out_data", bus.out_data, mq[0].d);
            chk("out_sum", bus.out_sum, mq[0].s);
            chk("out_max", bus.out_max, mq[0].mx);
            chk("out_min", bus.out_min, mq[0].mn);
        end else begin
            chk("out_data_idle", bus.out_data, 0);
            chk("out_sum_idle", bus.out_sum, 0);
        end
        chk("err", err, 32'(err_e));
        chk("ovf", ovf, 32'(ovf_e));
`ifdef RC_ERR_CNT_EN
        chk("err_cnt", err_cnt, cnt_e);
`endif
    endtask

    task automatic step(input logic v, input logic [5:0] r, input logic rdy);
        bus.in_valid  = v;
        bus.in_result = r;
        bus.out_ready = rdy;
        @(posedge clk);
        model_step(v, r, rdy);
        #1;
        model_cmp();
    endtask

    task automatic send(input logic [5:0] a, input logic [5:0] b,
                        input logic [5:0] c, input logic [5:0] d,
                        input logic rdy);
        step(1'b1, a, 1'b0);
        step(1'b1, b, 1'b0);
        step(1'b1, c, 1'b0);
        step(1'b1, d, rdy);
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_sum", bus.out_sum, 0);
        chk("rst_max", bus.out_max, 0);
        chk("rst_min", bus.out_min, 0);
        chk("rst_err", err, 0);
        chk("rst_ovf", ovf, 0);
`ifdef RC_ERR_CNT_EN
        chk("rst_cnt", err_cnt, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int pops;
        logic [7:0] exp_s[4];

        tbl[0] = '{6'h38, 6'h3D, 6'h02, 6'h07, 24'hE3D087, 8'hFE, 6'h07, 6'h38};
        tbl[1] = '{6'h1F, 6'h1F, 6'h1F, 6'h1F, 24'h7DF7DF, 8'h7C, 6'h1F, 6'h1F};
        tbl[2] = '{6'h20, 6'h20, 6'h20, 6'h20, 24'h820820, 8'h80, 6'h20, 6'h20};
        tbl[3] = '{6'h00, 6'h00, 6'h00, 6'h00, 24'h000000, 8'h00, 6'h00, 6'h00};
        tbl[4] = '{6'h1F, 6'h20, 6'h00, 6'h01, 24'h7E0001, 8'h00, 6'h1F, 6'h20};
        tbl[5] = '{6'h05, 6'h3F, 6'h3F, 6'h03, 24'h17FFC3, 8'h06, 6'h05, 6'h3F};

        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        foreach (tbl[i]) begin
            send(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3, 1'b1);
            chk("vec_valid", bus.out_valid, 1);
            chk("vec_data", bus.out_data, tbl[i].data);
            chk("vec_sum", bus.out_sum, tbl[i].sum);
            chk("vec_max", bus.out_max, tbl[i].mx);
            chk("vec_min", bus.out_min, tbl[i].mn);
            step(1'b0, 6'h00, 1'b1);
            chk("vec_drained", bus.out_valid, 0);
        end

        // truncated frame followed by a clean zero frame
        do_reset();
        step(1'b1, 6'h01, 1'b1);
        step(1'b1, 6'h02, 1'b1);
        step(1'b0, 6'h00, 1'b1);
        chk("trunc_err", err, 1);
        chk("trunc_noout", bus.out_valid, 0);
        step(1'b1, 6'h00, 1'b1);
        chk("trunc_err_clr", err, 0);
        step(1'b1, 6'h00, 1'b1);
        step(1'b1, 6'h00, 1'b1);
        step(1'b1, 6'h00, 1'b1);
        chk("trunc_zero_valid", bus.out_valid, 1);
        chk("trunc_zero_sum", bus.out_sum, 0);
`ifdef RC_ERR_CNT_EN
        chk("trunc_cnt", err_cnt, 1);
`endif
        step(1'b0, 6'h00, 1'b1);
        chk("trunc_one_frame", bus.out_valid, 0);

        // five back-to-back frames into a stalled reader
        do_reset();
        for (int f = 0; f < 5; f++) begin
            send(6'h1F, 6'h1F, 6'h1F, 6'h1F, 1'b0);
            chk("ovf_pulse", ovf, 32'(f == 4));
        end
        chk("ovf_sum", bus.out_sum, 8'h7C);
        step(1'b0, 6'h00, 1'b0);
        chk("ovf_one_cycle", ovf, 0);
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid) begin
                pops++;
                chk("ovf_pop_sum", bus.out_sum, 8'h7C);
            end
            step(1'b0, 6'h00, 1'b1);
        end
        chk("ovf_pops", pops, 4);

        // full FIFO with a pop on the push edge
        do_reset();
        for (int f = 0; f < 4; f++)
            send(6'h1F, 6'h1F, 6'h1F, 6'h1F, 1'b0);
        send(6'h01, 6'h02, 6'h03, 6'h04, 1'b1);
        chk("fullpop_no_ovf", ovf, 0);
        exp_s = '{8'h7C, 8'h7C, 8'h7C, 8'h0A};
        for (int i = 0; i < 4; i++) begin
            chk("fullpop_valid", bus.out_valid, 1);
            chk("fullpop_sum", bus.out_sum, exp_s[i]);
            if (i == 3) chk("fullpop_last", bus.out_data, 24'h0420C4);
            step(1'b0, 6'h00, 1'b1);
        end
        chk("fullpop_count4", bus.out_valid, 0);

        // reset mid-frame with a frame still waiting to drain
        do_reset();
        send(6'h05, 6'h3F, 6'h3F, 6'h03, 1'b0);
        step(1'b1, 6'h09, 1'b0);
        step(1'b1, 6'h0A, 1'b0);
        do_reset();
        send(6'h01, 6'h02, 6'h03, 6'h04, 1'b1);
        chk("post_rst_valid", bus.out_valid, 1);
        chk("post_rst_data", bus.out_data, 24'h0420C4);
        chk("post_rst_sum", bus.out_sum, 8'h0A);
        step(1'b0, 6'h00, 1'b1);

        // random traffic against the frame model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            logic v, rdy;
            v   = ($urandom_range(0, 9) != 0);
            rdy = (i < 1000) ? ($urandom_range(0, 3) == 0)
                             : ($urandom_range(0, 1) == 1);
            step(v, 6'($urandom), rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sort_result_collector.md
# sort_result_collector

Downstream consumer of the sort/calculate stage. Captures that stage's 4-beat signed result stream (6-bit values, one per cycle under a valid strobe), checks frame integrity, and computes per-frame sum/max/min. Buffers complete frames in a small FIFO that a downstream reader drains through a valid/ready handshake. Also flags truncated frames and FIFO overflow, since the upstream stage has no backpressure.

## Interface
- DEPTH, 4, FIFO depth in frames; power of 2, minimum 2.
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  result beat valid, from upstream out_valid.
- in_result  input  6  signed result beat, from upstream out_result.
- out_valid  output  1  head frame available.
- out_ready  input  1  reader accepts head frame.
- out_data  output  24  packed beats {r0,r1,r2,r3}, r0 in [23:18].
- out_sum  output  8  signed r0+r1+r2+r3.
- out_max  output  6  signed max of the four beats.
- out_min  output  6  signed min of the four beats.
- err  output  1  one-cycle pulse: truncated frame discarded.
- ovf  output  1  one-cycle pulse: complete frame dropped, FIFO full.
- err_cnt  output  8  saturating truncation count; present only with RC_ERR_CNT_EN.

## Operation
- Collector FSM: IDLE, COLLECT. A 2-bit beat counter `beat` tracks 0..3.
- IDLE:
  - in_valid=1: store beat 0, beat<=1, go to COLLECT.
  - Otherwise stay in IDLE.
- COLLECT with in_valid=1:
  - Store beat[beat].
  - If beat==3: push the frame, beat<=0, go to IDLE.
  - Otherwise beat increments.
- COLLECT with in_valid=0: truncated frame.
  - Discard the partial beats, beat<=0, go to IDLE.
  - err=1 on the next cycle.
- Back-to-back frames are legal: beat 0 of a new frame may arrive the cycle after beat 3 of the previous frame.
- The push uses beat 3 directly from in_result; beats 0..2 come from registers.
- Push arithmetic:
  - sum is sign-extended to 8 bits before adding. The range is -128..124, so it never overflows.
  - max and min use signed comparison. Ties are irrelevant to the result.
- FIFO entry is 44 bits: data, sum, max, min.
- Pop: out_valid && out_ready at a rising edge.
- Push acceptance: accepted if count<DEPTH, or if a pop occurs on the same edge.
  - Otherwise the frame is dropped and ovf=1 on the next cycle.
- Simultaneous push and pop: count is unchanged, head advances, tail advances.
- Output values:
  - out_valid = (count != 0).
  - out_data/out_sum/out_max/out_min show the head entry when out_valid=1, and are forced to 0 otherwise.
- Reading a non-empty FIFO requires an in-progress write to be complete. Reads never return partial entries.
- Reset, including mid-frame or mid-drain:
  - FSM to IDLE, beat=0, FIFO emptied.
  - Outputs: out_valid=0, out_data=0, out_sum=0, out_max=0, out_min=0, err=0, ovf=0, err_cnt=0.

## Timing
- Latency: a frame whose beat 3 is sampled at edge N has out_valid=1 from after edge N, provided it is accepted into an empty FIFO.
- err asserts after the edge that samples in_valid=0 in COLLECT, for exactly one cycle.
- ovf asserts after the edge of the rejected push, for exactly one cycle.
- err and ovf can never be high together, since they come from mutually exclusive collector events.
- out_* may change only at a pop or a push-into-empty. They hold stable while out_valid=1 and out_ready=0.
- Sustained throughput: one frame per 4 cycles in, one frame per cycle out.

## Configuration
- RC_ERR_CNT_EN defined:
  - Port err_cnt exists.
  - It increments on every err pulse and saturates at 255.
  - It is cleared only by reset.
- RC_ERR_CNT_EN undefined: port err_cnt and its counter are absent. All other behaviour is identical.

## Test plan
- Basic frame:
  - Stimulus: beats -8,-3,2,7 with out_ready=1.
  - Response: one cycle after beat 3, out_valid=1, out_data=24'hE3D087, out_sum=8'hFE, out_max=7, out_min=-8.
- Truncation:
  - Stimulus: beats 1,2, then in_valid=0, then a full frame 0,0,0,0.
  - Response: err pulses once. Only the zero frame is output (out_sum=0). err_cnt=1 when enabled.
- Overflow:
  - Stimulus: out_ready=0, DEPTH=4, 5 back-to-back frames of all 31.
  - Response: frames 1–4 are stored with out_sum=124. ovf pulses once after frame 5.
  - Then raise out_ready: exactly 4 pops.
- Full with simultaneous pop:
  - Stimulus: FIFO full, out_ready=1 on the same cycle as a frame push.
  - Response: no ovf, count stays at 4, the new frame appears last.
- Extremes and reset:
  - Stimulus: frame -32,-32,-32,-32.
  - Response: out_sum=8'h80 (-128), max=min=-32.
  - Then assert rst_n low mid-frame at beat 2: all outputs 0, and the next full frame is output normally.
